// File: rtl/unidade_proximo_pc_pkg.sv
// Shared definitions for the next-PC unit: redirect mode encodings and the
// parameter sanity check used by the target calculator.
package pacote_pc;

    localparam logic [1:0] MODO_BRANCH = 2'b00;
    localparam logic [1:0] MODO_JUMP   = 2'b01;
    localparam logic [1:0] MODO_JR     = 2'b10;
    localparam logic [1:0] MODO_TRAP   = 2'b11;

    // The shifted jump field must fit inside the address width.
    function automatic bit larguras_validas(input int largura, input int larg_alvo, input int desloc);
        return (larg_alvo + desloc) <= largura;
    endfunction

endpackage

// File: rtl/unidade_proximo_pc_calculo.sv
// Combinational redirect target selection (branch, pseudo-direct jump,
// jump-register, trap) plus the word-alignment check on the chosen target.
module calculo_alvo_pc
    import pacote_pc::*;
#(
    parameter int                 LARGURA       = 32,
    parameter int                 LARG_ALVO     = 26,
    parameter int                 DESLOC        = 2,
    parameter int                 PASSO         = 4,
    parameter logic [LARGURA-1:0] ENDERECO_TRAP = 32'h0000_0080
) (
    input  logic [1:0]           modo,
    input  logic [LARGURA-1:0]   pc_origem,
    input  logic [LARGURA-1:0]   deslocamento,
    input  logic [LARG_ALVO-1:0] alvo_jump,
    input  logic [LARGURA-1:0]   registrador,
    output logic [LARGURA-1:0]   alvo,
    output logic                 desalinhado
);

    localparam int                 BITS_JUMP     = LARG_ALVO + DESLOC;
    localparam logic [LARGURA-1:0] MASCARA_JUMP  = ~({LARGURA{1'b1}} << BITS_JUMP);
    localparam logic [LARGURA-1:0] MASCARA_ALINH = ~({LARGURA{1'b1}} << DESLOC);

    if (!larguras_validas(LARGURA, LARG_ALVO, DESLOC)) begin : g_largura_invalida
        $error("LARG_ALVO + DESLOC exceeds LARGURA");
    end

    logic [LARGURA-1:0] proximo_seq_s;
    logic [LARGURA-1:0] campo_jump_s;

    // Target mux; jump keeps only the top bits of the sequential successor.
    always_comb begin
        proximo_seq_s = pc_origem + LARGURA'(PASSO);
        campo_jump_s  = LARGURA'(alvo_jump) << DESLOC;
        case (modo)
            MODO_BRANCH: alvo = proximo_seq_s + (deslocamento << DESLOC);
            MODO_JUMP:   alvo = (proximo_seq_s & ~MASCARA_JUMP) | campo_jump_s;
            MODO_JR:     alvo = registrador;
            MODO_TRAP:   alvo = ENDERECO_TRAP;
            default:     alvo = ENDERECO_TRAP;
        endcase
        desalinhado = |(alvo & MASCARA_ALINH);
    end

endmodule

// File: rtl/unidade_proximo_pc.sv
// Next-PC unit: owns the PC register, presents it to instruction memory with
// valid/ready, and applies redirects (buffered once while frozen).
module unidade_proximo_pc
    import pacote_pc::*;
#(
    parameter int                 LARGURA        = 32,
    parameter int                 LARG_ALVO      = 26,
    parameter int                 PASSO          = 4,
    parameter int                 DESLOC         = 2,
    parameter logic [LARGURA-1:0] ENDERECO_RESET = 32'h0000_0000,
    parameter logic [LARGURA-1:0] ENDERECO_TRAP  = 32'h0000_0080
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 congela,
    input  logic                 pc_ready,
    output logic                 pc_valid,
    output logic [LARGURA-1:0]   pc_atual,
    input  logic                 redir_valid,
    input  logic [1:0]           redir_modo,
    input  logic [LARGURA-1:0]   pc_origem,
    input  logic [LARGURA-1:0]   deslocamento,
    input  logic [LARG_ALVO-1:0] alvo_jump,
    input  logic [LARGURA-1:0]   registrador,
    output logic                 erro_alinhamento,
    output logic [LARGURA-1:0]   endereco_erro
);

    logic [LARGURA-1:0] alvo_s;
    logic               desalinhado_s;
    logic               redir_ok_s;
    logic               pc_valid_s;

    logic [LARGURA-1:0] pc_d, pc_q;
    logic               valido_d, valido_q;
    logic               pendente_d, pendente_q;
    logic [LARGURA-1:0] buffer_d, buffer_q;
    logic               erro_d, erro_q;
    logic [LARGURA-1:0] end_erro_d, end_erro_q;

    calculo_alvo_pc #(
        .LARGURA       (LARGURA),
        .LARG_ALVO     (LARG_ALVO),
        .DESLOC        (DESLOC),
        .PASSO         (PASSO),
        .ENDERECO_TRAP (ENDERECO_TRAP)
    ) u_calculo (
        .modo         (redir_modo),
        .pc_origem    (pc_origem),
        .deslocamento (deslocamento),
        .alvo_jump    (alvo_jump),
        .registrador  (registrador),
        .alvo         (alvo_s),
        .desalinhado  (desalinhado_s)
    );

    // Next-state: freeze buffers redirects; otherwise live redirect beats buffer beats advance.
    always_comb begin
        redir_ok_s = redir_valid & ~desalinhado_s;
        pc_valid_s = valido_q & ~congela;
        pc_d       = pc_q;
        pendente_d = pendente_q;
        buffer_d   = buffer_q;
        valido_d   = 1'b1;
        erro_d     = redir_valid & desalinhado_s;
        if (redir_valid && desalinhado_s) begin
            end_erro_d = alvo_s;
        end else begin
            end_erro_d = end_erro_q;
        end
        if (congela) begin
            if (redir_ok_s) begin
                buffer_d   = alvo_s;
                pendente_d = 1'b1;
            end else begin
                buffer_d   = buffer_q;
            end
        end else if (redir_ok_s) begin
            pc_d       = alvo_s;
            pendente_d = 1'b0;
        end else if (pendente_q) begin
            pc_d       = buffer_q;
            pendente_d = 1'b0;
        end else if (pc_valid_s && pc_ready) begin
            pc_d       = pc_q + LARGURA'(PASSO);
        end else begin
            pc_d       = pc_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q       <= ENDERECO_RESET;
            valido_q   <= 1'b0;
            pendente_q <= 1'b0;
            buffer_q   <= {LARGURA{1'b0}};
            erro_q     <= 1'b0;
            end_erro_q <= {LARGURA{1'b0}};
        end else begin
            pc_q       <= pc_d;
            valido_q   <= valido_d;
            pendente_q <= pendente_d;
            buffer_q   <= buffer_d;
            erro_q     <= erro_d;
            end_erro_q <= end_erro_d;
        end
    end

    assign pc_atual         = pc_q;
    assign pc_valid         = pc_valid_s;
    assign erro_alinhamento = erro_q;
    assign endereco_erro    = end_erro_q;

endmodule

// File: tb/tb_unidade_proximo_pc.sv
// Bench for unidade_proximo_pc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_unidade_proximo_pc;

    logic        clock = 1'b0;
    logic        reset_n, congela, pc_ready, redir_valid;
    logic [1:0]  redir_modo;
    logic [31:0] pc_origem, deslocamento, registrador;
    logic [25:0] alvo_jump;
    logic        pc_valid, erro_alinhamento;
    logic [31:0] pc_atual, endereco_erro;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    logic [31:0] m_pc, m_buf, m_erraddr;
    bit          m_valid, m_pend, m_err;

    always #5 clock = ~clock;

    unidade_proximo_pc dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .congela          (congela),
        .pc_ready         (pc_ready),
        .pc_valid         (pc_valid),
        .pc_atual         (pc_atual),
        .redir_valid      (redir_valid),
        .redir_modo       (redir_modo),
        .pc_origem        (pc_origem),
        .deslocamento     (deslocamento),
        .alvo_jump        (alvo_jump),
        .registrador      (registrador),
        .erro_alinhamento (erro_alinhamento),
        .endereco_erro    (endereco_erro)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [1:0] modo);
        logic [31:0] seq;
        seq = pc_origem + 32'd4;
        case (modo)
            2'd0:    return seq + deslocamento * 32'd4;
            2'd1:    return (seq & 32'hF000_0000) + {6'd0, alvo_jump} * 32'd4;
            2'd2:    return registrador;
            default: return 32'h0000_0080;
        endcase
    endfunction

    // Behavioural model advanced at every rising edge.
    always @(posedge clock) begin
        logic [31:0] t;
        bit ok;
        if (!reset_n) begin
            m_pc = 32'd0; m_valid = 0; m_pend = 0; m_err = 0; m_erraddr = 32'd0;
        end else begin
            t  = target_of(redir_modo);
            ok = redir_valid && (t % 32'd4 == 32'd0);
            m_err = redir_valid && !ok;
            if (m_err) m_erraddr = t;
            if (congela) begin
                if (ok) begin m_buf = t; m_pend = 1; end
            end else if (ok) begin
                m_pc = t; m_pend = 0;
            end else if (m_pend) begin
                m_pc = m_buf; m_pend = 0;
            end else if (m_valid && pc_ready) begin
                m_pc = m_pc + 32'd4;
            end
            m_valid = 1;
        end
    end

    // Compare process on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("pc_atual", pc_atual, m_pc);
            chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid && !congela});
            chk("erro_alinhamento", {31'd0, erro_alinhamento}, {31'd0, m_err});
            chk("endereco_erro", endereco_erro, m_erraddr);
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic redir(input logic [1:0] modo, input logic [31:0] reg_v);
        redir_valid = 1'b1;
        redir_modo  = modo;
        registrador = reg_v;
    endtask

    initial begin
        reset_n = 1'b0; congela = 1'b0; pc_ready = 1'b0; redir_valid = 1'b0;
        redir_modo = 2'd0; pc_origem = 32'd0; deslocamento = 32'd0;
        registrador = 32'd0; alvo_jump = 26'd0;
        nxt();
        chk_en = 1'b1;
        nxt();
        chk("reset pc", pc_atual, 32'h0);
        chk("reset valid", {31'd0, pc_valid}, 32'd0);

        reset_n = 1'b1; pc_ready = 1'b1;
        nxt(); chk("seq0", pc_atual, 32'h0); chk("valid first edge", {31'd0, pc_valid}, 32'd1);
        nxt(); chk("seq1", pc_atual, 32'h4);
        nxt(); chk("seq2", pc_atual, 32'h8);
        nxt(); chk("seq3", pc_atual, 32'hC);

        redir(2'd0, 32'd0); pc_origem = 32'h100; deslocamento = 32'hFFFF_FFFE;
        nxt(); chk("branch", pc_atual, 32'hFC);
        redir(2'd1, 32'd0); pc_origem = 32'h1000_0000; alvo_jump = 26'h40;
        nxt(); chk("jump", pc_atual, 32'h1000_0100);

        redir_valid = 1'b0; congela = 1'b1;
        nxt(); chk("frozen hold", pc_atual, 32'h1000_0100); chk("frozen valid", {31'd0, pc_valid}, 32'd0);
        redir(2'd2, 32'h200);
        nxt();
        redir(2'd2, 32'h300);
        nxt(); chk("frozen hold2", pc_atual, 32'h1000_0100);
        redir_valid = 1'b0; congela = 1'b0;
        nxt(); chk("buffered newest", pc_atual, 32'h300);

        redir(2'd2, 32'h202);
        nxt();
        chk("misalign pulse", {31'd0, erro_alinhamento}, 32'd1);
        chk("misalign addr", endereco_erro, 32'h202);
        chk("misalign seq", pc_atual, 32'h304);
        redir_valid = 1'b0;
        nxt();
        chk("pulse once", {31'd0, erro_alinhamento}, 32'd0);
        chk("addr held", endereco_erro, 32'h202);

        redir(2'd2, 32'hFFFF_FFFC);
        nxt(); redir_valid = 1'b0;
        nxt(); chk("wrap", pc_atual, 32'h0);
        redir(2'd3, 32'd0);
        nxt(); chk("trap", pc_atual, 32'h80);

        congela = 1'b1; redir(2'd2, 32'h400);
        nxt();
        redir_valid = 1'b0; reset_n = 1'b0; congela = 1'b0;
        nxt(); chk("reset clears pc", pc_atual, 32'h0);
        reset_n = 1'b1;
        nxt(); chk("no stale buffer", pc_atual, 32'h0);
        nxt(); chk("seq after reset", pc_atual, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            reset_n      = ($urandom_range(0, 99) != 0);
            congela      = ($urandom_range(0, 4) == 0);
            pc_ready     = ($urandom_range(0, 2) != 0);
            redir_valid  = ($urandom_range(0, 3) == 0);
            redir_modo   = 2'($urandom_range(0, 3));
            pc_origem    = $urandom & 32'hFFFF_FFFC;
            deslocamento = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            alvo_jump    = 26'($urandom);
            registrador  = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
